stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control/sequencing block for the 4-digit BCD stopwatch datapath.
- Conditions the raw pushbuttons: 2-FF synchroniser, debounce, rising-edge press pulse.
- Runs the IDLE/RUN/STOP/LAP state machine and generates the gated 100 Hz count-enable tick.
- Issues the clear and lap-freeze controls that the digit counters and display consume.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 100, count-tick rate. TICK_DIV = CLK_HZ/TICK_HZ, must be an integer ≥ 2.
- DEBOUNCE_CYC, 1_000_000, consecutive stable cycles required before the debounced level changes. Must be ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start_stop_btn  in  1  raw asynchronous pushbutton, active-high.
- lap_btn  in  1  raw asynchronous pushbutton, active-high.
- clear_btn  in  1  raw asynchronous pushbutton, active-high.
- max_reached  in  1  from datapath; high while the digits read 99.99.
- tick  out  1  one-cycle count-enable pulse to the digit counters.
- count_clr  out  1  one-cycle synchronous clear to the digit counters.
- lap_hold  out  1  high = display shows the frozen lap value.
- running  out  1  high in RUN or LAP.
- state  out  2  IDLE=0, RUN=1, STOP=2, LAP=3.

Behaviour:
- Reset (reset_n low at a clk edge): all outputs 0, state=IDLE. Synchronisers, debounced levels, debounce counters, press pulses and tick divider all 0. Reset overrides any operation in progress.
- Per-button conditioning:
  - s1 <= raw; s2 <= s1.
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYC-1: db <= s2, cnt <= 0.
  - Else: cnt++.
  - press <= db & ~db_prev, registered, one cycle wide.
- Press latency: raw high, sampled first at edge 1 and held → db=1 after edge DEBOUNCE_CYC+2 → press high for exactly the cycle after edge DEBOUNCE_CYC+3.
- Glitches: any bounce shorter than DEBOUNCE_CYC cycles yields no press. Release produces no press.
- Held button: a button held across reset release produces one press DEBOUNCE_CYC+3 cycles after release.
- Press priority in the same cycle: clear > start_stop > lap. Only the highest-priority press valid in the current state acts; the others are discarded.
- FSM transitions, registered, effective the edge after the press cycle:
  - IDLE: start_stop → RUN. lap and clear ignored.
  - RUN: start_stop → STOP. lap → LAP. clear ignored.
  - LAP: lap → RUN. start_stop → STOP. clear ignored.
  - STOP: start_stop → RUN. clear → IDLE. lap ignored.
  - RUN or LAP with max_reached=1 → STOP, taking precedence over any press.
- Outputs, all registered and consistent with state:
  - running = (state==RUN || state==LAP).
  - lap_hold = (state==LAP); it drops on entry to RUN or STOP.
  - count_clr = 1 for exactly the first cycle state==IDLE after leaving STOP. It does not pulse on reset.
- Tick divider:
  - Counts 0..TICK_DIV-1 only while running.
  - tick=1 in the cycle the divider equals TICK_DIV-1 (registered pulse); the divider then wraps to 0.
  - Divider holds its value in STOP, so a resumed run completes the partial period.
  - Divider is zeroed on entry to IDLE.
  - tick is forced 0 in any cycle max_reached=1.
  - In RUN/LAP, exactly one tick every TICK_DIV cycles, no jitter.

Test Plan (CLK_HZ=1000, TICK_HZ=100 → TICK_DIV=10, DEBOUNCE_CYC=4):
- Reset, then raw start_stop held high from edge 1 → press after edge 7; state=RUN, running=1 after edge 8; tick pulses every 10 cycles thereafter.
- start_stop bounce of 3-cycle high pulses separated by 2-cycle lows for 30 cycles, then low → no press, state stays IDLE, tick never asserted.
- RUN, divider at 6, start_stop press → state=STOP, no ticks. Resume via start_stop → first tick exactly 3 cycles after running=1, then every 10.
- STOP, clear and start_stop pressed in the same cycle → state=IDLE, count_clr high exactly one cycle, running=0, divider=0; in IDLE a lap press leaves state=0.
- RUN, lap press → state=LAP, lap_hold=1, ticks continue uninterrupted. Second lap press → RUN, lap_hold=0. Lap then start_stop → STOP with lap_hold=0.
- RUN with max_reached asserted → tick suppressed that cycle, state=STOP next edge; a simultaneous lap press is ignored. reset_n low mid-RUN → all outputs 0, state=IDLE on that edge.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
//  Module      : stopwatch_ctrl_if
//  Description : Button, status and control signals between the stopwatch
//                controller and the digit datapath / display.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;
   logic       start_stop_btn;
   logic       lap_btn;
   logic       clear_btn;
   logic       max_reached;
   logic       tick;
   logic       count_clr;
   logic       lap_hold;
   logic       running;
   logic [1:0] state;

   modport master (
      output start_stop_btn, lap_btn, clear_btn, max_reached,
      input  tick, count_clr, lap_hold, running, state
   );

   modport slave (
      input  start_stop_btn, lap_btn, clear_btn, max_reached,
      output tick, count_clr, lap_hold, running, state
   );
endinterface

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Button conditioning, IDLE/RUN/STOP/LAP sequencing and gated
//                count-tick generation for the 4-digit BCD stopwatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TICK_HZ      = 100,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic            clk,
   input  logic            reset_n,
   stopwatch_ctrl_if.slave sw
);

   localparam int c_TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int c_DIV_W    = $clog2(c_TICK_DIV);
   localparam int c_DEB_W    = $clog2(DEBOUNCE_CYC);
   localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(c_TICK_DIV - 1);
   localparam logic [c_DEB_W-1:0] c_DEB_MAX = c_DEB_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2,
      S_LAP  = 2'd3
   } state_t;

   // Button index: 0 = start_stop, 1 = lap, 2 = clear
   logic [2:0]         w_raw;
   logic [2:0]         w_press;
   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_running;
   logic               r_lap_hold;
   logic               r_count_clr;
   logic [c_DIV_W-1:0] r_div;

   assign w_raw = {sw.clear_btn, sw.lap_btn, sw.start_stop_btn};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         logic               r_s1;
         logic               r_s2;
         logic               r_db;
         logic               r_db_prev;
         logic               r_press;
         logic [c_DEB_W-1:0] r_cnt;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_s1      <= 1'b0;
               r_s2      <= 1'b0;
               r_db      <= 1'b0;
               r_db_prev <= 1'b0;
               r_press   <= 1'b0;
               r_cnt     <= '0;
            end else begin
               r_s1      <= w_raw[gi];
               r_s2      <= r_s1;
               r_db_prev <= r_db;
               r_press   <= r_db & ~r_db_prev;
               // Level only follows after DEBOUNCE_CYC consecutive disagreeing samples
               if (r_s2 == r_db) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_DEB_MAX) begin
                  r_db  <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_DEB_W'(1);
               end
            end
         end

         assign w_press[gi] = r_press;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_running   <= 1'b0;
         r_lap_hold  <= 1'b0;
         r_count_clr <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_running   <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
         r_lap_hold  <= (w_state_nxt == S_LAP);
         r_count_clr <= (r_state == S_STOP) && (w_state_nxt == S_IDLE);
      end
   end

   // Priority clear > start_stop > lap falls out of the if/else ordering
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_press[0]) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (sw.max_reached)   w_state_nxt = S_STOP;
            else if (w_press[0])  w_state_nxt = S_STOP;
            else if (w_press[1])  w_state_nxt = S_LAP;
         end
         S_LAP: begin
            if (sw.max_reached)   w_state_nxt = S_STOP;
            else if (w_press[0])  w_state_nxt = S_STOP;
            else if (w_press[1])  w_state_nxt = S_RUN;
         end
         S_STOP: begin
            if (w_press[2])       w_state_nxt = S_IDLE;
            else if (w_press[0])  w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Divider freezes in STOP so a resumed run finishes the partial period
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_div <= '0;
      end else if (r_running) begin
         r_div <= (r_div == c_DIV_MAX) ? '0 : r_div + c_DIV_W'(1);
      end else if ((r_state == S_STOP) && (w_state_nxt == S_IDLE)) begin
         r_div <= '0;
      end
   end

   assign sw.tick      = r_running && (r_div == c_DIV_MAX) && !sw.max_reached;
   assign sw.count_clr = r_count_clr;
   assign sw.lap_hold  = r_lap_hold;
   assign sw.running   = r_running;
   assign sw.state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Randomised button/max_reached stimulus for stopwatch_ctrl,
//                checked against a transition-table reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DEB     = 4;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   stopwatch_ctrl_if sw ();

   stopwatch_ctrl #(
      .CLK_HZ       (CLK_HZ),
      .TICK_HZ      (TICK_HZ),
      .DEBOUNCE_CYC (DEB)
   ) u_dut (
      .clk     (clk),
      .reset_n (rst_n),
      .sw      (sw)
   );

   always #5 clk = ~clk;

   // Reference model: 0=IDLE 1=RUN 2=STOP 3=LAP
   int m_state;
   int m_phase;
   bit m_clr;
   bit m_s1  [3];
   bit m_s2  [3];
   bit m_db  [3];
   bit m_dbp [3];
   bit m_prs [3];
   int m_run_len [3];

   // Destination of a press of button b in state s, or -1 when ignored
   function automatic int dest(input int s, input int b);
      case (b)
         0: return (s == 0) ? 1 : (s == 1) ? 2 : (s == 2) ? 1 : 2;
         1: return (s == 1) ? 3 : (s == 3) ? 1 : -1;
         default: return (s == 2) ? 0 : -1;
      endcase
   endfunction

   function automatic bit is_running(input int s);
      return (s == 1) || (s == 3);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit [2:0] raw;
      int nxt;
      int prio [3];
      bit done;
      raw  = {sw.clear_btn, sw.lap_btn, sw.start_stop_btn};
      prio = '{2, 0, 1};
      if (!rst_n) begin
         m_state = 0;
         m_phase = 0;
         m_clr   = 1'b0;
         for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbp[b] = 0;
            m_prs[b] = 0; m_run_len[b] = 0;
         end
         return;
      end
      nxt  = m_state;
      done = 1'b0;
      if (is_running(m_state) && sw.max_reached) begin
         nxt = 2;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (!done && m_prs[prio[i]] && dest(m_state, prio[i]) >= 0) begin
               nxt  = dest(m_state, prio[i]);
               done = 1'b1;
            end
         end
      end
      if (is_running(m_state)) m_phase = (m_phase + 1) % DIV;
      else if (m_state == 2 && nxt == 0) m_phase = 0;
      m_clr   = (m_state == 2) && (nxt == 0);
      m_state = nxt;
      for (int b = 0; b < 3; b++) begin
         m_prs[b] = m_db[b] & ~m_dbp[b];
         m_dbp[b] = m_db[b];
         if (m_s2[b] == m_db[b]) begin
            m_run_len[b] = 0;
         end else begin
            m_run_len[b]++;
            if (m_run_len[b] == DEB) begin
               m_db[b]      = m_s2[b];
               m_run_len[b] = 0;
            end
         end
         m_s2[b] = m_s1[b];
         m_s1[b] = raw[b];
      end
   endtask

   task automatic compare();
      chk("state",     int'(sw.state),     m_state);
      chk("running",   int'(sw.running),   int'(is_running(m_state)));
      chk("lap_hold",  int'(sw.lap_hold),  int'(m_state == 3));
      chk("count_clr", int'(sw.count_clr), int'(m_clr));
      chk("tick",      int'(sw.tick),
          int'(is_running(m_state) && m_phase == DIV - 1 && !sw.max_reached));
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_btn(input bit [2:0] m);
      sw.start_stop_btn = m[0];
      sw.lap_btn        = m[1];
      sw.clear_btn      = m[2];
   endtask

   task automatic press(input bit [2:0] m);
      set_btn(m);
      repeat (6) step();
      set_btn(3'b000);
      repeat (8) step();
   endtask

   initial begin
      int  ticks;
      int  act;
      bit [2:0] mask;

      rst_n          = 1'b0;
      sw.max_reached = 1'b0;
      set_btn(3'b000);
      repeat (2) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      step();
      step();

      // Start held from the first edge after reset release
      rst_n = 1'b1;
      set_btn(3'b001);
      repeat (7) step();
      chk("plan_pre_run", int'(sw.state), 0);
      step();
      chk("plan_run", int'(sw.state), 1);
      chk("plan_running", int'(sw.running), 1);
      set_btn(3'b000);
      ticks = 0;
      repeat (30) begin
         step();
         ticks += int'(sw.tick);
      end
      chk("plan_tick_count", ticks, 3);

      press(3'b001);
      chk("plan_stop", int'(sw.state), 2);
      press(3'b101);
      chk("plan_clr_idle", int'(sw.state), 0);
      press(3'b010);
      chk("plan_idle_lap", int'(sw.state), 0);

      for (int n = 0; n < 160; n++) begin
         act = int'($urandom_range(0, 11));
         if (act <= 4) begin
            mask = 3'($urandom_range(1, 7));
            if (act <= 2) mask = 3'(1 << $urandom_range(0, 2));
            set_btn(mask);
            repeat ($urandom_range(3, 8)) step();
            set_btn(3'b000);
            repeat ($urandom_range(5, 9)) step();
         end else if (act == 5) begin
            repeat ($urandom_range(3, 8)) begin
               set_btn(3'($urandom_range(0, 7)));
               repeat ($urandom_range(1, 3)) step();
               set_btn(3'b000);
               repeat ($urandom_range(1, 3)) step();
            end
            repeat (6) step();
         end else if (act == 6) begin
            sw.max_reached = 1'b1;
            if ($urandom_range(0, 1) == 1) set_btn(3'b010);
            repeat ($urandom_range(1, 3)) step();
            sw.max_reached = 1'b0;
            repeat ($urandom_range(2, 6)) step();
            set_btn(3'b000);
            repeat (6) step();
         end else if (act == 7 && $urandom_range(0, 3) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) step();
            rst_n = 1'b1;
         end else begin
            repeat ($urandom_range(1, 25)) step();
         end
      end
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
